// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared types and sizing helpers for the iterative multiplier
// Purpose: FSM state encoding plus cycle-count / counter-width helpers used by
//          seq_multiplier and its datapath sub-blocks.
// Ports:   none (package).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of RUN cycles that carry an addition.
  function automatic int mult_cycles(input int width, input int step);
    return width / step;
  endfunction

  // Counter must reach N itself, hence N+1 distinct values.
  function automatic int mult_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STEP  = 1;
  localparam int DEFAULT_CNT_W = $clog2(mult_cycles(DEFAULT_WIDTH, DEFAULT_STEP) + 1);

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - request/result bundle between pipeline and multiplier
// Purpose: groups the start/ready handshake, operands and result of seq_multiplier.
// Ports (modport slave = multiplier side):
//   start, is_signed, a[WIDTH], b[WIDTH]           in  request and operands
//   busy, ready, product_lo, product_hi, overflow  out status and result
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;

  modport master (
    output start, is_signed, a, b,
    input  busy, ready, product_lo, product_hi, overflow
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, ready, product_lo, product_hi, overflow
  );

endinterface

// File: rtl/seq_multiplier_cla.sv
// rtl/seq_multiplier_cla.sv - carry-lookahead adder, 4-bit lookahead groups
// Purpose: W-bit sum without carry-in or carry-out; groups of four bits resolve
//          their carries in parallel, group carries chain between groups.
// Ports:   x[W], y[W] in addends; sum[W] out (modulo 2^W).
module mult_cla_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  localparam int NB = W / 4;

  // bc[k] is the carry into group k.
  logic [NB-1:0] bc;

  assign bc[0] = 1'b0;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [3:0] xs;
    logic [3:0] ys;
    logic [3:0] pb;
    logic [2:0] gb;
    logic [3:0] cb;

    assign xs = x[4*k +: 4];
    assign ys = y[4*k +: 4];
    assign pb = xs ^ ys;
    assign gb = xs[2:0] & ys[2:0];

    assign cb[0] = bc[k];
    assign cb[1] = gb[0] | (pb[0] & cb[0]);
    assign cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cb[0]);
    assign cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & cb[0]);

    assign sum[4*k +: 4] = pb ^ cb;

    if (k < NB - 1) begin : g_carry
      assign bc[k+1] = (xs[3] & ys[3]) | (pb[3] & cb[3]);
    end
  end

endmodule

// File: rtl/seq_multiplier_step_add.sv
// rtl/seq_multiplier_step_add.sv - one partial-product step of the iterative multiplier
// Purpose: forms multiplicand x STEP-bit multiplier slice, places it at bit
//          position cnt*STEP and adds it to the accumulator.
// Ports:   mcand[WIDTH], slice[STEP], cnt[CNT_W], acc[2*WIDTH] in;
//          sum[2*WIDTH] out.
module mult_step_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [STEP-1:0]    slice,
  input  logic [CNT_W-1:0]   cnt,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] sum
);

  logic [WIDTH+STEP-1:0] partial;
  logic [2*WIDTH-1:0]    addend;

  // STEP is at most 4, so a short shift-and-add chain is cheap here.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (slice[i]) begin
        partial = partial + ({{STEP{1'b0}}, mcand} << i);
      end
    end
  end

  assign addend = {{(WIDTH-STEP){1'b0}}, partial} << (int'(cnt) * STEP);

  mult_cla_adder #(
    .W(2*WIDTH)
  ) u_cla (
    .x  (acc),
    .y  (addend),
    .sum(sum)
  );

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative signed/unsigned WIDTHxWIDTH multiplier
// Purpose: retires STEP multiplier bits per cycle on operand magnitudes, then
//          applies the sign and registers the double-width product and overflow.
// Ports:   clock, reset (sync, active high);
//          bus (seq_multiplier_if.slave): start, is_signed, a, b in;
//          busy, ready, product_lo, product_hi, overflow out.
// Option:  SEQ_MULT_EARLY_EXIT_EN - a zero operand skips straight to DONE.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);

  localparam int N     = mult_cycles(WIDTH, STEP);
  localparam int CNT_W = mult_cnt_width(N);

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;
  logic [CNT_W-1:0]   cnt;
  logic               negate;
  logic               signed_mode;
  logic [WIDTH-1:0]   prod_lo_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic               ovf_q;
  logic               ovf_calc;
  logic               busy_o;
  logic               ready_o;
  logic               accept;
  logic               run_last;
  logic               zero_exit;

  // DONE doubles as an accepting state so results can issue back to back.
  assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;
  // The cycle with cnt == N adds nothing; it is the hand-off into FIX.
  assign run_last = (state == RUN) && (cnt == CNT_W'(N));

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Operands are checked on the first RUN cycle, once they are latched.
  assign zero_exit = (state == RUN) && (cnt == '0)
                   && ((mcand == '0) || (mplier == '0));
`else
  assign zero_exit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (zero_exit)     state_next = DONE;
        else if (run_last) state_next = FIX;
      end
      FIX: begin
        busy_o     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ready_o    = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mult_step_add #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .CNT_W(CNT_W)
  ) u_step_add (
    .mcand(mcand),
    .slice(mplier[STEP-1:0]),
    .cnt  (cnt),
    .acc  (acc),
    .sum  (acc_sum)
  );

  // The magnitude product is at most 2^(2W-2), so negation never wraps.
  assign result   = negate ? -acc : acc;
  assign ovf_calc = signed_mode
                  ? (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}})
                  : (result[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      negate      <= 1'b0;
      signed_mode <= 1'b0;
      prod_lo_q   <= '0;
      prod_hi_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        signed_mode <= bus.is_signed;
        negate      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        // -(2^(W-1)) reads back as 2^(W-1) unsigned, which is the magnitude.
        mcand       <= (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mplier      <= (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        acc         <= '0;
        cnt         <= '0;
      end else if ((state == RUN) && !run_last) begin
        acc    <= acc_sum;
        mplier <= mplier >> STEP;
        cnt    <= cnt + CNT_W'(1);
      end

      if (state == FIX) begin
        prod_lo_q <= result[WIDTH-1:0];
        prod_hi_q <= result[2*WIDTH-1:WIDTH];
        ovf_q     <= ovf_calc;
      end else if (zero_exit) begin
        prod_lo_q <= '0;
        prod_hi_q <= '0;
        ovf_q     <= 1'b0;
      end
    end
  end

  assign bus.busy       = busy_o;
  assign bus.ready      = ready_o;
  assign bus.product_lo = prod_lo_q;
  assign bus.product_hi = prod_hi_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
// Purpose: drives STEP=1 and STEP=4 instances with hand-computed vectors.
// Ports:   none (top-level bench).
module tb_seq_multiplier;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_multiplier_if #(.WIDTH(32)) m1 ();
  seq_multiplier_if #(.WIDTH(32)) m4 ();

  seq_multiplier #(.WIDTH(32), .STEP(1)) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (m1.slave)
  );

  seq_multiplier #(.WIDTH(32), .STEP(4)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (m4.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  task automatic drive(input bit use4, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic sgn);
    if (use4) begin
      m4.start = st; m4.a = a; m4.b = b; m4.is_signed = sgn;
    end else begin
      m1.start = st; m1.a = a; m1.b = b; m1.is_signed = sgn;
    end
  endtask

  task automatic sample(input bit use4, output logic rdy, output logic bsy,
                        output logic [31:0] lo, output logic [31:0] hi, output logic ov);
    if (use4) begin
      rdy = m4.ready; bsy = m4.busy; lo = m4.product_lo; hi = m4.product_hi; ov = m4.overflow;
    end else begin
      rdy = m1.ready; bsy = m1.busy; lo = m1.product_lo; hi = m1.product_hi; ov = m1.overflow;
    end
  endtask

  // Issues one operation; lat is the edge (counting the accepting edge as 0)
  // after which ready was seen, or -1 when the budget ran out.
  task automatic run_op(input bit use4, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int limit, output int lat,
                        output logic [31:0] lo, output logic [31:0] hi, output logic ov);
    logic rdy, bsy;
    drive(use4, 1'b1, a, b, sgn);
    @(posedge clock); #1;
    drive(use4, 1'b0, a, b, sgn);
    lat = -1;
    lo = '0; hi = '0; ov = 1'b0;
    for (int k = 1; k <= limit && lat < 0; k++) begin
      @(posedge clock); #1;
      sample(use4, rdy, bsy, lo, hi, ov);
      if (rdy === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    logic rdy, bsy, ov;
    logic [31:0] lo, hi;
    sample(1'b0, rdy, bsy, lo, hi, ov);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", rdy); end
    n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bsy); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_product: got %h expected 0", {hi, lo}); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", ov); end
    sample(1'b1, rdy, bsy, lo, hi, ov);
    n_cmp++; if ({rdy, bsy, ov, hi, lo} !== 67'h0) begin n_bad++; $display("FAIL reset_step4: got %h expected 0", {rdy, bsy, ov, hi, lo}); end
  endtask

  task automatic test_unsigned_wrap();
    int lat; logic [31:0] lo, hi; logic ov;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 60, lat, lo, hi, ov);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL uwrap_latency: got %0d expected 34", lat); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL uwrap_lo: got %h expected 00000001", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL uwrap_hi: got %h expected fffffffe", hi); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL uwrap_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_signed_small();
    int lat; logic [31:0] lo, hi; logic ov;
    run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 60, lat, lo, hi, ov);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL ssmall_latency: got %0d expected 34", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL ssmall_lo: got %h expected ffffffeb", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ssmall_hi: got %h expected ffffffff", hi); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL ssmall_ovf: got %b expected 0", ov); end
  endtask

  task automatic test_signed_corner();
    int lat; logic [31:0] lo, hi; logic ov;
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 60, lat, lo, hi, ov);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL scorner_lo: got %h expected 80000000", lo); end
    n_cmp++; if (hi !== 32'h0000_0000) begin n_bad++; $display("FAIL scorner_hi: got %h expected 00000000", hi); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL scorner_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_handshake();
    int lat; logic [31:0] lo, hi; logic ov, rdy, bsy;
    drive(1'b0, 1'b1, 32'd1000, 32'd3000, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'd1000, 32'd3000, 1'b0);
    sample(1'b0, rdy, bsy, lo, hi, ov);
    n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL hs_busy_edge0: got %b expected 1", bsy); end
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (k == 5 || k == 20) drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
      else                   drive(1'b0, 1'b0, 32'd1000, 32'd3000, 1'b0);
      @(posedge clock); #1;
      sample(1'b0, rdy, bsy, lo, hi, ov);
      if (rdy === 1'b1) lat = k;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL hs_latency: got %0d expected 34", lat); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0000_002D_C6C0) begin n_bad++; $display("FAIL hs_product: got %h expected 00000000002dc6c0", {hi, lo}); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL hs_ovf: got %b expected 0", ov); end
    n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL hs_busy_done: got %b expected 0", bsy); end
    // Issued from the DONE cycle: no idle bubble.
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 60, lat, lo, hi, ov);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL b2b_product: got %h expected 0000000100000000", {hi, lo}); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_step4();
    int lat; logic [31:0] lo, hi; logic ov;
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 30, lat, lo, hi, ov);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL step4_latency: got %0d expected 10", lat); end
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL step4_product: got %h expected ffffffffffffffeb", {hi, lo}); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL step4_ovf: got %b expected 0", ov); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] lo, hi; logic ov, rdy, bsy; bit seen;
    drive(1'b0, 1'b1, 32'h0001_2345, 32'h0000_6789, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'h0001_2345, 32'h0000_6789, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      if (m1.ready === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sample(1'b0, rdy, bsy, lo, hi, ov);
    n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", bsy); end
    n_cmp++; if ({hi, lo, ov} !== 65'h0) begin n_bad++; $display("FAIL rmid_outputs: got %h expected 0", {hi, lo, ov}); end
    for (int k = 0; k < 40; k++) begin
      if (m1.ready === 1'b1) seen = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_ready: got %b expected 0", seen); end
    run_op(1'b0, 32'd6, 32'd7, 1'b0, 60, lat, lo, hi, ov);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL rmid_next_latency: got %0d expected 34", lat); end
    n_cmp++; if ({hi, lo} !== 64'd42) begin n_bad++; $display("FAIL rmid_next_product: got %h expected 42", {hi, lo}); end
  endtask

  task automatic test_zero_operand();
    int lat; logic [31:0] lo, hi; logic ov;
    run_op(1'b0, 32'h0000_0000, 32'h0000_1234, 1'b0, 60, lat, lo, hi, ov);
    n_cmp++; if (lat !== ZERO_LAT) begin n_bad++; $display("FAIL zero_latency: got %0d expected %0d", lat, ZERO_LAT); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL zero_product: got %h expected 0", {hi, lo}); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL zero_ovf: got %b expected 0", ov); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    test_unsigned_wrap();
    test_signed_small();
    test_signed_corner();
    test_handshake();
    test_step4();
    test_reset_mid();
    test_zero_operand();
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
